// File: rtl/pipe_mem_arbiter_if.sv
// Bus bundle between the pipeline's two memory requesters (fetch, load/store),
// the arbiter and the single-port memory array.
//   slave  : arbiter view (takes requests, returns acks, drives the memory)
//   master : requester/memory view (drives requests and mem_rdata)
// Signals:
//   if_req/if_addr/if_flush -> fetch request, address, branch flush pulse
//   if_ack/if_rdata         <- fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata -> data request, store flag, address, store data
//   d_ack/d_rdata           <- data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata <- memory strobe and write controls
//   mem_rdata               -> memory read data (fixed latency after mem_en)
interface pipe_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_ack, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_ack, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the MEM stage.
// One access at a time; the data port has priority, but after MAX_STREAK
// consecutive data grants with fetch waiting, fetch gets the next slot.
// A taken-branch flush drops the in-flight fetch result without disturbing
// memory timing.
// Ports:
//   clk1  : clock, everything on posedge
//   rst_n : synchronous active-low reset
//   bus   : pipe_mem_arbiter_if.slave (requests, acks, memory interface)
//   busy  : high whenever the FSM is not in IDLE
// All outputs come straight from flops.
//
// state | meaning
// IDLE  | arbitrate; also the cycle in which the previous ack is pulsed
// ISSUE | mem_en strobe for the granted access (one cycle)
// WAIT  | read latency countdown; capture mem_rdata on terminal count
module pipe_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  pipe_mem_arbiter_if.slave bus,
  output logic              busy
);

  localparam int CW = 3;
  localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT);
  localparam logic [3:0]    STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;     // 1 = data port owns the access
  logic [3:0]    streak_q, streak_d;
  logic          drop_q, drop_d;       // in-flight fetch was flushed
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;

  logic          d_wins;
  logic          fetch_dropped;

  // Data wins unless fetch is waiting and the data streak is exhausted.
  assign d_wins        = bus.d_req && (!bus.if_req || (streak_q < STREAK_MAX));
  // A flush arriving in the final WAIT cycle must still kill this ack.
  assign fetch_dropped = drop_q || bus.if_flush;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      streak_q    <= '0;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (d_wins) begin
          state_d     = S_ISSUE;
          owner_d     = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          if (!bus.if_req) begin
            streak_d = '0;
          end else if (streak_q < STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (bus.if_req) begin
          state_d    = S_ISSUE;
          owner_d    = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = bus.if_addr;
          streak_d   = '0;
        end
      end

      S_ISSUE: begin
        if (!owner_q && bus.if_flush) begin
          drop_d = 1'b1;
        end
        // mem_we_q is only ever set for a data store.
        if (mem_we_q) begin
          state_d = S_IDLE;
          d_ack_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = LAT_LOAD;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (!owner_q && bus.if_flush) begin
          drop_d = 1'b1;
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (owner_q) begin
            d_rdata_d = bus.mem_rdata;
            d_ack_d   = 1'b1;
          end else if (!fetch_dropped) begin
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Randomized bench for pipe_mem_arbiter. A transaction-level model tracks the
// single outstanding access (grant cycle, owner, duration, expected data from a
// shadow memory) and predicts every output cycle by cycle.
module tb_pipe_mem_arbiter;
  localparam int AW         = 10;
  localparam int DW         = 16;
  localparam int MEM_LAT    = 2;
  localparam int MAX_STREAK = 4;
  localparam int NCYC       = 4000;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  pipe_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  pipe_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk1 (clk1),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0:       return '1;
      1:       return '0;
      2, 3:    return AW'($urandom_range(16, 19));
      default: return AW'($urandom);
    endcase
  endfunction

  // memory environment
  logic [DW-1:0] mem    [1<<AW];
  logic [DW-1:0] shadow [1<<AW];
  logic [DW-1:0] slot_d [8];
  bit            slot_v [8];

  // reference model of the one outstanding access
  bit            act;
  int            g, dur;
  bit            m_data, m_we, m_flushed, post_rst;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_exp;
  int            streak;
  logic [DW-1:0] e_if_rdata, e_d_rdata;
  int            n_resets;

  task automatic new_data_req();
    bus.d_req   = 1'b1;
    bus.d_we    = ($urandom_range(0, 2) == 0);
    bus.d_addr  = rand_addr();
    bus.d_wdata = DW'($urandom);
  endtask

  initial begin
    bit done;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = DW'($urandom);
      shadow[i] = mem[i];
    end
    for (int i = 0; i < 8; i++) slot_v[i] = 1'b0;
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;
    act = 0; streak = 0; e_if_rdata = '0; e_d_rdata = '0; post_rst = 0; n_resets = 0;
    m_flushed = 0; g = 0; dur = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    check_val("rst_if_ack", bus.if_ack, 0);
    check_val("rst_d_ack", bus.d_ack, 0);
    check_val("rst_mem_en", bus.mem_en, 0);
    check_val("rst_mem_we", bus.mem_we, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_if_rdata", bus.if_rdata, 0);
    check_val("rst_d_rdata", bus.d_rdata, 0);
    check_val("rst_mem_addr", bus.mem_addr, 0);
    check_val("rst_mem_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;

    for (cyc = 1; cyc <= NCYC; cyc++) begin
      @(posedge clk1);
      #1;

      // memory array behaviour
      if (bus.mem_en === 1'b1) begin
        if (bus.mem_we === 1'b1) begin
          mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          slot_d[(cyc + MEM_LAT) % 8] = mem[bus.mem_addr];
          slot_v[(cyc + MEM_LAT) % 8] = 1'b1;
        end
      end

      // expectations for this cycle
      done = act && (cyc == g + dur);
      if (done && m_data && !m_we) e_d_rdata = m_exp;
      if (done && !m_data && !m_flushed) e_if_rdata = m_exp;

      check_val("mem_en", bus.mem_en, act && (cyc == g + 1));
      if (act && (cyc == g + 1)) begin
        check_val("mem_we", bus.mem_we, m_we);
        check_val("mem_addr", bus.mem_addr, m_addr);
        if (m_we) check_val("mem_wdata", bus.mem_wdata, m_wdata);
      end
      check_val("d_ack", bus.d_ack, done && m_data);
      check_val("if_ack", bus.if_ack, done && !m_data && !m_flushed);
      check_val("busy", busy, act && (cyc > g) && (cyc < g + dur));
      check_val("if_rdata", bus.if_rdata, e_if_rdata);
      check_val("d_rdata", bus.d_rdata, e_d_rdata);
      if (post_rst) begin
        check_val("post_rst_mem_addr", bus.mem_addr, 0);
        check_val("post_rst_mem_wdata", bus.mem_wdata, 0);
        check_val("post_rst_mem_we", bus.mem_we, 0);
        post_rst = 0;
      end
      if (done) act = 0;

      // stimulus for this cycle
      if (n_resets < 3 && cyc > 800 * (n_resets + 1) && act && m_data && !m_we && cyc == g + 2)
        rst_n = 1'b0;
      else
        rst_n = 1'b1;

      if (bus.d_ack === 1'b1) begin
        if ($urandom_range(0, 9) < 8) new_data_req();
        else bus.d_req = 1'b0;
      end else if (!bus.d_req && $urandom_range(0, 3) == 0) begin
        new_data_req();
      end

      bus.if_flush = ($urandom_range(0, 11) == 0);
      if (bus.if_flush) begin
        bus.if_req  = 1'b1;
        bus.if_addr = rand_addr();
      end else if (bus.if_ack === 1'b1) begin
        if ($urandom_range(0, 9) < 7) bus.if_addr = AW'(bus.if_addr + 1);
        else bus.if_req = 1'b0;
      end else if (!bus.if_req && $urandom_range(0, 9) < 3) begin
        bus.if_req  = 1'b1;
        bus.if_addr = rand_addr();
      end

      if (slot_v[cyc % 8]) begin
        bus.mem_rdata = slot_d[cyc % 8];
        slot_v[cyc % 8] = 1'b0;
      end else begin
        bus.mem_rdata = DW'($urandom);
      end

      // model update from this cycle's inputs
      if (!rst_n) begin
        act = 0; streak = 0; e_if_rdata = '0; e_d_rdata = '0;
        post_rst = 1; n_resets++;
      end else begin
        if (act && !m_data && bus.if_flush && cyc > g) m_flushed = 1;
        if (!act) begin
          if (bus.d_req && (!bus.if_req || streak < MAX_STREAK)) begin
            act = 1; g = cyc; m_data = 1; m_flushed = 0;
            m_we = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
            if (bus.if_req) streak = (streak < MAX_STREAK) ? streak + 1 : streak;
            else streak = 0;
            if (m_we) shadow[m_addr] = m_wdata;
            else m_exp = shadow[m_addr];
            dur = m_we ? 2 : MEM_LAT + 2;
          end else if (bus.if_req) begin
            act = 1; g = cyc; m_data = 0; m_flushed = 0; m_we = 0;
            m_addr = bus.if_addr; m_exp = shadow[m_addr];
            streak = 0;
            dur = MEM_LAT + 2;
          end
        end
      end
    end

    check_val("resets_exercised", (n_resets > 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
